// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection, flush and debug-halt hold.
// Optional bubble counter enabled by defining ID_EX_STALL_CNT_EN.
module id_ex_stage_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic              i_flush,
  input  logic              i_reg_dst,
  input  logic              i_alu_src_b,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic              i_mem_to_reg,
  input  logic              i_reg_write,
  input  logic [2:0]        i_alu_op,
  input  logic [2:0]        i_branch_type,
  input  logic [5:0]        i_funct,
  input  logic [DATA_W-1:0] i_pc_plus4,
  input  logic [DATA_W-1:0] i_rs_data,
  input  logic [DATA_W-1:0] i_rt_data,
  input  logic [DATA_W-1:0] i_imm_ext,
  input  logic [REG_AW-1:0] i_rs,
  input  logic [REG_AW-1:0] i_rt,
  input  logic [REG_AW-1:0] i_rd,
  output logic              o_stall,
  output logic              o_reg_dst,
  output logic              o_alu_src_b,
  output logic              o_mem_read,
  output logic              o_mem_write,
  output logic              o_mem_to_reg,
  output logic              o_reg_write,
  output logic [2:0]        o_alu_op,
  output logic [2:0]        o_branch_type,
  output logic [5:0]        o_funct,
  output logic [DATA_W-1:0] o_pc_plus4,
  output logic [DATA_W-1:0] o_rs_data,
  output logic [DATA_W-1:0] o_rt_data,
  output logic [DATA_W-1:0] o_imm_ext,
  output logic [REG_AW-1:0] o_rs,
  output logic [REG_AW-1:0] o_rt,
  output logic [REG_AW-1:0] o_rd,
  output logic [31:0]       o_stall_count
);

  // Decoder encodings shared with the ID control unit.
  localparam logic [2:0] BRANCH_TYPE_NONE = 3'd0;
  localparam logic [2:0] BRANCH_TYPE_BEQ  = 3'd1;
  localparam logic [2:0] BRANCH_TYPE_BNE  = 3'd2;
  localparam logic [2:0] BRANCH_TYPE_J    = 3'd3;
  localparam logic [2:0] BRANCH_TYPE_JAL  = 3'd4;
  localparam logic [2:0] BRANCH_TYPE_JR   = 3'd5;
  localparam logic [2:0] BRANCH_TYPE_JALR = 3'd6;
  localparam logic       CTRL_ALU_SRC_B_REG = 1'b0;

  typedef struct packed {
    logic              reg_dst;
    logic              alu_src_b;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
    logic              reg_write;
    logic [2:0]        alu_op;
    logic [2:0]        branch_type;
    logic [5:0]        funct;
    logic [DATA_W-1:0] pc_plus4;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm_ext;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
  } idex_t;

  idex_t stage_d, stage_q;
  logic  rs_used, rt_used, hazard;

  assign rs_used = (i_branch_type != BRANCH_TYPE_J) && (i_branch_type != BRANCH_TYPE_JAL);
  assign rt_used = (i_alu_src_b == CTRL_ALU_SRC_B_REG) || i_mem_write;

  // $zero is never a real producer, so a load targeting it cannot create a hazard.
  assign hazard = stage_q.mem_read && (stage_q.rt != '0) &&
                  ((rs_used && (i_rs == stage_q.rt)) || (rt_used && (i_rt == stage_q.rt)));
  assign o_stall = hazard && i_enable && !i_flush;

  always_comb begin
    stage_d = '{reg_dst: i_reg_dst, alu_src_b: i_alu_src_b, mem_read: i_mem_read,
                mem_write: i_mem_write, mem_to_reg: i_mem_to_reg, reg_write: i_reg_write,
                alu_op: i_alu_op, branch_type: i_branch_type, funct: i_funct,
                pc_plus4: i_pc_plus4, rs_data: i_rs_data, rt_data: i_rt_data,
                imm_ext: i_imm_ext, rs: i_rs, rt: i_rt, rd: i_rd};
    if (i_flush || o_stall) begin
      stage_d = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      stage_q <= '0;
    end else if (i_enable) begin
      stage_q <= stage_d;
    end
  end

  assign o_reg_dst     = stage_q.reg_dst;
  assign o_alu_src_b   = stage_q.alu_src_b;
  assign o_mem_read    = stage_q.mem_read;
  assign o_mem_write   = stage_q.mem_write;
  assign o_mem_to_reg  = stage_q.mem_to_reg;
  assign o_reg_write   = stage_q.reg_write;
  assign o_alu_op      = stage_q.alu_op;
  assign o_branch_type = stage_q.branch_type;
  assign o_funct       = stage_q.funct;
  assign o_pc_plus4    = stage_q.pc_plus4;
  assign o_rs_data     = stage_q.rs_data;
  assign o_rt_data     = stage_q.rt_data;
  assign o_imm_ext     = stage_q.imm_ext;
  assign o_rs          = stage_q.rs;
  assign o_rt          = stage_q.rt;
  assign o_rd          = stage_q.rd;

`ifdef ID_EX_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Only stall bubbles count; o_stall already excludes flush and halt cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (o_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_stall_count = stall_cnt_q;
`else
  assign o_stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed testbench for id_ex_stage_reg: reset, load-use stall, $zero, flush, halt, rt usage.
module tb_id_ex_stage_reg;

  logic        clk, rst, en, flush;
  logic        reg_dst, alu_src_b, mem_read, mem_write, mem_to_reg, reg_write;
  logic [2:0]  alu_op, branch_type;
  logic [5:0]  funct;
  logic [31:0] pc_plus4, rs_data, rt_data, imm_ext;
  logic [4:0]  rs, rt, rd;
  logic        o_stall, o_reg_dst, o_alu_src_b, o_mem_read, o_mem_write, o_mem_to_reg, o_reg_write;
  logic [2:0]  o_alu_op, o_branch_type;
  logic [5:0]  o_funct;
  logic [31:0] o_pc_plus4, o_rs_data, o_rt_data, o_imm_ext, o_stall_count;
  logic [4:0]  o_rs, o_rt, o_rd;

  int passed = 0;
  int total  = 0;
  logic [31:0] exp_cnt = 0;

  id_ex_stage_reg #(.DATA_W(32), .REG_AW(5)) dut (
    .i_clk(clk), .i_reset(rst), .i_enable(en), .i_flush(flush),
    .i_reg_dst(reg_dst), .i_alu_src_b(alu_src_b), .i_mem_read(mem_read),
    .i_mem_write(mem_write), .i_mem_to_reg(mem_to_reg), .i_reg_write(reg_write),
    .i_alu_op(alu_op), .i_branch_type(branch_type), .i_funct(funct),
    .i_pc_plus4(pc_plus4), .i_rs_data(rs_data), .i_rt_data(rt_data), .i_imm_ext(imm_ext),
    .i_rs(rs), .i_rt(rt), .i_rd(rd),
    .o_stall(o_stall), .o_reg_dst(o_reg_dst), .o_alu_src_b(o_alu_src_b),
    .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .o_mem_to_reg(o_mem_to_reg),
    .o_reg_write(o_reg_write), .o_alu_op(o_alu_op), .o_branch_type(o_branch_type),
    .o_funct(o_funct), .o_pc_plus4(o_pc_plus4), .o_rs_data(o_rs_data),
    .o_rt_data(o_rt_data), .o_imm_ext(o_imm_ext), .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd),
    .o_stall_count(o_stall_count)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Decoded instruction presented by ID.
  task automatic set_lw(input logic [4:0] base, input logic [4:0] dst, input logic [31:0] pc);
    reg_dst = 0; alu_src_b = 1; mem_read = 1; mem_write = 0; mem_to_reg = 1; reg_write = 1;
    alu_op = 3'd0; branch_type = 3'd0; funct = 6'd0; pc_plus4 = pc;
    rs_data = 32'h1000; rt_data = 32'h0; imm_ext = 32'h4; rs = base; rt = dst; rd = 5'd0;
  endtask

  task automatic set_add(input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                         input logic [31:0] pc);
    reg_dst = 1; alu_src_b = 0; mem_read = 0; mem_write = 0; mem_to_reg = 0; reg_write = 1;
    alu_op = 3'd2; branch_type = 3'd0; funct = 6'h20; pc_plus4 = pc;
    rs_data = 32'h11; rt_data = 32'h22; imm_ext = 32'h0; rs = s; rt = t; rd = d;
  endtask

  task automatic set_addi(input logic [4:0] s, input logic [4:0] t, input logic [31:0] imm);
    reg_dst = 0; alu_src_b = 1; mem_read = 0; mem_write = 0; mem_to_reg = 0; reg_write = 1;
    alu_op = 3'd0; branch_type = 3'd0; funct = 6'd0; pc_plus4 = 32'h500;
    rs_data = 32'h7; rt_data = 32'h0; imm_ext = imm; rs = s; rt = t; rd = 5'd0;
  endtask

  task automatic set_sw(input logic [4:0] s, input logic [4:0] t);
    reg_dst = 0; alu_src_b = 1; mem_read = 0; mem_write = 1; mem_to_reg = 0; reg_write = 0;
    alu_op = 3'd0; branch_type = 3'd0; funct = 6'd0; pc_plus4 = 32'h600;
    rs_data = 32'h2000; rt_data = 32'hAB; imm_ext = 32'h8; rs = s; rt = t; rd = 5'd0;
  endtask

  task automatic test_reset();
    rst = 1; en = 1; flush = 0;
    set_add(5'd0, 5'd0, 5'd0, 32'h0);
    #12;
    rst = 0;
    #1;
    total++; if (o_mem_read !== 1'b0 || o_pc_plus4 !== 32'h0) $display("FAIL reset_state: mem_read=%0b pc=%h, want 0/0", o_mem_read, o_pc_plus4); else passed++;
    set_lw(5'd29, 5'd8, 32'h104);
    tick();
    total++; if (o_mem_read !== 1'b1 || o_rt !== 5'd8) $display("FAIL reset_lw_load: mem_read=%0b rt=%0d, want 1/8", o_mem_read, o_rt); else passed++;
    set_add(5'd8, 5'd9, 5'd10, 32'h108);
    #1;
    total++; if (o_stall !== 1'b1) $display("FAIL reset_pre_stall: stall=%0b, want 1", o_stall); else passed++;
    #1 rst = 1;
    #1;
    total++; if (o_stall !== 1'b0) $display("FAIL reset_stall_drop: stall=%0b, want 0", o_stall); else passed++;
    total++; if (o_mem_read !== 1'b0 || o_rt !== 5'd0 || o_pc_plus4 !== 32'h0 || o_reg_write !== 1'b0 || o_imm_ext !== 32'h0)
      $display("FAIL reset_async_clear: mem_read=%0b rt=%0d pc=%h rw=%0b imm=%h, want all 0", o_mem_read, o_rt, o_pc_plus4, o_reg_write, o_imm_ext);
    else passed++;
    total++; if (o_stall_count !== 32'h0) $display("FAIL reset_count: count=%0d, want 0", o_stall_count); else passed++;
    exp_cnt = 0;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_load_use();
    set_lw(5'd29, 5'd8, 32'h104);
    tick();
    set_add(5'd8, 5'd9, 5'd10, 32'h108);
    #1;
    total++; if (o_stall !== 1'b1) $display("FAIL lu_stall: stall=%0b, want 1", o_stall); else passed++;
    tick();
`ifdef ID_EX_STALL_CNT_EN
    exp_cnt = exp_cnt + 1;
`endif
    total++; if (o_mem_read !== 1'b0 || o_reg_write !== 1'b0 || o_rd !== 5'd0 || o_pc_plus4 !== 32'h0)
      $display("FAIL lu_bubble: mem_read=%0b rw=%0b rd=%0d pc=%h, want 0/0/0/0", o_mem_read, o_reg_write, o_rd, o_pc_plus4);
    else passed++;
    total++; if (o_stall !== 1'b0) $display("FAIL lu_no_repeat: stall=%0b, want 0", o_stall); else passed++;
    total++; if (o_stall_count !== exp_cnt) $display("FAIL lu_count: count=%0d, want %0d", o_stall_count, exp_cnt); else passed++;
    tick();
    total++; if (o_reg_write !== 1'b1 || o_rd !== 5'd10 || o_funct !== 6'h20 || o_rs_data !== 32'h11 || o_pc_plus4 !== 32'h108)
      $display("FAIL lu_consumer: rw=%0b rd=%0d funct=%h rsd=%h pc=%h, want 1/10/20/11/108", o_reg_write, o_rd, o_funct, o_rs_data, o_pc_plus4);
    else passed++;
  endtask

  task automatic test_reg_zero();
    set_lw(5'd29, 5'd0, 32'h204);
    tick();
    set_add(5'd0, 5'd0, 5'd12, 32'h208);
    #1;
    total++; if (o_stall !== 1'b0) $display("FAIL zero_no_stall: stall=%0b, want 0", o_stall); else passed++;
    tick();
    total++; if (o_rd !== 5'd12 || o_reg_write !== 1'b1 || o_pc_plus4 !== 32'h208)
      $display("FAIL zero_latch: rd=%0d rw=%0b pc=%h, want 12/1/208", o_rd, o_reg_write, o_pc_plus4);
    else passed++;
  endtask

  task automatic test_flush_vs_stall();
    set_lw(5'd29, 5'd8, 32'h304);
    tick();
    set_add(5'd8, 5'd9, 5'd10, 32'h308);
    flush = 1;
    #1;
    total++; if (o_stall !== 1'b0) $display("FAIL flush_stall_forced: stall=%0b, want 0", o_stall); else passed++;
    tick();
    flush = 0;
    total++; if (o_mem_read !== 1'b0 || o_reg_write !== 1'b0 || o_pc_plus4 !== 32'h0 || o_rd !== 5'd0)
      $display("FAIL flush_bubble: mem_read=%0b rw=%0b pc=%h rd=%0d, want 0/0/0/0", o_mem_read, o_reg_write, o_pc_plus4, o_rd);
    else passed++;
    total++; if (o_stall_count !== exp_cnt) $display("FAIL flush_count: count=%0d, want %0d", o_stall_count, exp_cnt); else passed++;
  endtask

  task automatic test_enable();
    set_lw(5'd29, 5'd8, 32'h300);
    tick();
    en = 0;
    for (int i = 0; i < 3; i++) begin
      set_add(5'd8, 5'd8, 5'(i + 1), 32'h400 + 32'(i));
      #1;
      total++; if (o_stall !== 1'b0) $display("FAIL halt_stall%0d: stall=%0b, want 0", i, o_stall); else passed++;
      tick();
      total++; if (o_pc_plus4 !== 32'h300 || o_mem_read !== 1'b1 || o_rt !== 5'd8)
        $display("FAIL halt_hold%0d: pc=%h mem_read=%0b rt=%0d, want 300/1/8", i, o_pc_plus4, o_mem_read, o_rt);
      else passed++;
    end
    en = 1;
    set_addi(5'd4, 5'd9, 32'h0000_0005);
    #1;
    total++; if (o_stall !== 1'b0) $display("FAIL resume_no_stall: stall=%0b, want 0", o_stall); else passed++;
    tick();
    total++; if (o_imm_ext !== 32'h5 || o_rt !== 5'd9 || o_mem_read !== 1'b0 || o_alu_src_b !== 1'b1)
      $display("FAIL resume_addi: imm=%h rt=%0d mem_read=%0b asb=%0b, want 5/9/0/1", o_imm_ext, o_rt, o_mem_read, o_alu_src_b);
    else passed++;
    total++; if (o_stall_count !== exp_cnt) $display("FAIL halt_count: count=%0d, want %0d", o_stall_count, exp_cnt); else passed++;
  endtask

  task automatic test_rt_usage();
    set_lw(5'd29, 5'd10, 32'h700);
    tick();
    set_addi(5'd4, 5'd10, 32'h1);
    #1;
    total++; if (o_stall !== 1'b0) $display("FAIL addi_rt_unused: stall=%0b, want 0", o_stall); else passed++;
    set_add(5'd10, 5'd3, 5'd5, 32'h704);
    branch_type = 3'd3;
    #1;
    total++; if (o_stall !== 1'b0) $display("FAIL j_rs_unused: stall=%0b, want 0", o_stall); else passed++;
    branch_type = 3'd5;
    #1;
    total++; if (o_stall !== 1'b1) $display("FAIL jr_rs_used: stall=%0b, want 1", o_stall); else passed++;
    set_sw(5'd4, 5'd10);
    #1;
    total++; if (o_stall !== 1'b1) $display("FAIL sw_rt_used: stall=%0b, want 1", o_stall); else passed++;
    tick();
`ifdef ID_EX_STALL_CNT_EN
    exp_cnt = exp_cnt + 1;
`endif
    total++; if (o_mem_write !== 1'b0 || o_stall_count !== exp_cnt)
      $display("FAIL sw_bubble: mem_write=%0b count=%0d, want 0/%0d", o_mem_write, o_stall_count, exp_cnt);
    else passed++;
    tick();
    total++; if (o_mem_write !== 1'b1 || o_rt !== 5'd10 || o_rt_data !== 32'hAB)
      $display("FAIL sw_latch: mem_write=%0b rt=%0d rtd=%h, want 1/10/ab", o_mem_write, o_rt, o_rt_data);
    else passed++;
  endtask

  task automatic test_back_to_back();
    set_lw(5'd29, 5'd8, 32'h800);
    tick();
    set_lw(5'd8, 5'd9, 32'h804);
    #1;
    total++; if (o_stall !== 1'b1) $display("FAIL b2b_stall1: stall=%0b, want 1", o_stall); else passed++;
    tick();
    tick();
`ifdef ID_EX_STALL_CNT_EN
    exp_cnt = exp_cnt + 1;
`endif
    total++; if (o_mem_read !== 1'b1 || o_rt !== 5'd9 || o_pc_plus4 !== 32'h804)
      $display("FAIL b2b_lw2: mem_read=%0b rt=%0d pc=%h, want 1/9/804", o_mem_read, o_rt, o_pc_plus4);
    else passed++;
    set_add(5'd9, 5'd2, 5'd11, 32'h808);
    #1;
    total++; if (o_stall !== 1'b1) $display("FAIL b2b_stall2: stall=%0b, want 1", o_stall); else passed++;
    tick();
`ifdef ID_EX_STALL_CNT_EN
    exp_cnt = exp_cnt + 1;
`endif
    tick();
    total++; if (o_rd !== 5'd11 || o_stall_count !== exp_cnt)
      $display("FAIL b2b_final: rd=%0d count=%0d, want 11/%0d", o_rd, o_stall_count, exp_cnt);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_reg_zero();
    test_flush_vs_stall();
    test_enable();
    test_rt_usage();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
